// File: rtl/core_bin_loader.sv
// rtl/core_bin_loader.sv - feeds one bin into a sat_engine, runs it, and streams the clause array back
//
// Purpose: writes NUM_CLAUSES clause words into the engine with one-hot
// strobes, strobes the var/lvl state load, pulses start with base-level
// enable, waits for done, latches the result, then reads the clause array
// back out through a valid/ready stream and pulses done_o.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_start_i             start request (accepted only when idle)
//   in_clause_*              upstream clause stream (valid/ready/word)
//   out_clause_*             readback clause stream (valid/ready/word)
//   busy_o, done_o           status; done_o is a one-cycle pulse
//   result_o, bkt_lvl_o      0=PSAT 1=BKT 2=UNSAT 3=TIMEOUT, latched backtrack level
//   core_*                   engine-side strobes, words and status
//
// Optional feature: define CORE_BIN_LOADER_TIMEOUT_EN to bound the wait for
// core_done_i by TIMEOUT_CYCLES; expiry reports result 3 and skips readback.
module core_bin_loader #(
    parameter int NUM_CLAUSES    = 8,
    parameter int NUM_VARS       = 8,
    parameter int WIDTH_LVL      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start_i,
    input  logic                   in_clause_valid_i,
    output logic                   in_clause_ready_o,
    input  logic [NUM_VARS*2-1:0]  in_clause_i,
    output logic                   out_clause_valid_o,
    input  logic                   out_clause_ready_i,
    output logic [NUM_VARS*2-1:0]  out_clause_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [1:0]             result_o,
    output logic [WIDTH_LVL-1:0]   bkt_lvl_o,
    output logic [NUM_CLAUSES-1:0] core_wr_carray_o,
    output logic [NUM_VARS*2-1:0]  core_clause_o,
    output logic                   core_wr_states_o,
    output logic                   core_start_o,
    output logic                   core_base_lvl_en_o,
    output logic [NUM_CLAUSES-1:0] core_rd_carray_o,
    input  logic [NUM_VARS*2-1:0]  core_clause_i,
    input  logic                   core_done_i,
    input  logic                   core_sat_i,
    input  logic                   core_unsat_i,
    input  logic [WIDTH_LVL-1:0]   core_bkt_lvl_i
);

    localparam int IW = $clog2(NUM_CLAUSES) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CLAUSES - 1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_WR_CL  = 4'd1;
    localparam logic [3:0] S_WR_ST  = 4'd2;
    localparam logic [3:0] S_START  = 4'd3;
    localparam logic [3:0] S_WAIT   = 4'd4;
    localparam logic [3:0] S_RD_REQ = 4'd5;
    localparam logic [3:0] S_RD_CAP = 4'd6;
    localparam logic [3:0] S_RD_OUT = 4'd7;
    localparam logic [3:0] S_FIN    = 4'd8;

    // The done-blanking window must close before the watchdog can expire.
    generate
        if (TIMEOUT_CYCLES < 3) begin : g_cfg_check
            $error("TIMEOUT_CYCLES must be at least 3");
        end
    endgenerate

    logic [3:0]    state;
    logic [IW-1:0] idx;
    // Counts WAIT cycles up to 2; done is only trusted once it saturates, so
    // a done left over from the previous run (or asserted in the start cycle)
    // cannot complete this one.
    logic [1:0]    guard;
    logic          done_take;

`ifdef CORE_BIN_LOADER_TIMEOUT_EN
    logic [31:0]   to_cnt;
`endif

    assign done_take          = (state == S_WAIT) && (guard == 2'd2) && core_done_i;
    assign in_clause_ready_o  = (state == S_WR_CL);
    assign busy_o             = (state != S_IDLE);
    assign done_o             = (state == S_FIN);
    assign core_rd_carray_o   = (state == S_RD_REQ) ? (NUM_CLAUSES'(1) << idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_IDLE;
            idx                <= '0;
            guard              <= '0;
            out_clause_valid_o <= 1'b0;
            out_clause_o       <= '0;
            result_o           <= 2'd0;
            bkt_lvl_o          <= '0;
            core_wr_carray_o   <= '0;
            core_clause_o      <= '0;
            core_wr_states_o   <= 1'b0;
            core_start_o       <= 1'b0;
            core_base_lvl_en_o <= 1'b0;
`ifdef CORE_BIN_LOADER_TIMEOUT_EN
            to_cnt             <= '0;
`endif
        end else begin
            // Engine write-side strobes are single-cycle pulses by default.
            core_wr_carray_o   <= '0;
            core_wr_states_o   <= 1'b0;
            core_start_o       <= 1'b0;
            core_base_lvl_en_o <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (load_start_i) begin
                        state <= S_WR_CL;
                        idx   <= '0;
                    end
                end
                S_WR_CL: begin
                    if (in_clause_valid_i) begin
                        core_wr_carray_o <= NUM_CLAUSES'(1) << idx;
                        core_clause_o    <= in_clause_i;
                        idx              <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state <= S_WR_ST;
                        end
                    end
                end
                S_WR_ST: begin
                    core_wr_states_o <= 1'b1;
                    state            <= S_START;
                end
                S_START: begin
                    core_start_o       <= 1'b1;
                    core_base_lvl_en_o <= 1'b1;
                    guard              <= '0;
                    state              <= S_WAIT;
`ifdef CORE_BIN_LOADER_TIMEOUT_EN
                    to_cnt             <= '0;
`endif
                end
                S_WAIT: begin
                    if (guard != 2'd2) begin
                        guard <= guard + 1'b1;
                    end
                    if (done_take) begin
                        if (core_unsat_i) begin
                            result_o <= 2'd2;
                        end else if (core_sat_i) begin
                            result_o <= 2'd0;
                        end else begin
                            result_o <= 2'd1;
                        end
                        bkt_lvl_o <= core_bkt_lvl_i;
                        idx       <= '0;
                        state     <= S_RD_REQ;
                    end
`ifdef CORE_BIN_LOADER_TIMEOUT_EN
                    else if (to_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                        result_o <= 2'd3;
                        state    <= S_FIN;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end
                S_RD_REQ: begin
                    state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    out_clause_o       <= core_clause_i;
                    out_clause_valid_o <= 1'b1;
                    state              <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (out_clause_ready_i) begin
                        out_clause_valid_o <= 1'b0;
                        idx                <= idx + 1'b1;
                        state              <= (idx == LAST_IDX) ? S_FIN : S_RD_REQ;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/core_bin_loader.md
# core_bin_loader

Hardware feeder for one `sat_engine` instance. It streams a bin's NUM_CLAUSES clauses into the engine's clause array using one-hot write strobes, then strobes the var/lvl state load and pulses start with base-level enable. It waits for `done_core`, latches the result, reads the updated clause array back out through a ready/valid stream, and reports completion. It sits between the bin manager (upstream) and `sat_engine`; the top level routes `cur_bin_num`, `load_lvl`, `base_lvl`, `var_states` and `lvl_states` to the engine directly.

## Interface
- NUM_CLAUSES, 8, clauses per bin; one-hot strobe width
- NUM_VARS, 8, variables per bin; clause word is NUM_VARS*2 bits
- WIDTH_LVL, 16, level width
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with the macro)
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- load_start_i  in  1  start request; accepted only in IDLE
- in_clause_valid_i  in  1  upstream clause beat valid
- in_clause_ready_o  out  1  high in WR_CL
- in_clause_i  in  NUM_VARS*2  clause word
- out_clause_valid_o  out  1  readback word valid
- out_clause_ready_i  in  1  downstream accepts readback word
- out_clause_o  out  NUM_VARS*2  readback word; held while valid
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- result_o  out  2  0=PSAT, 1=BKT, 2=UNSAT, 3=TIMEOUT; held until next accepted start
- bkt_lvl_o  out  WIDTH_LVL  latched `core_bkt_lvl_i`
- core_wr_carray_o  out  NUM_CLAUSES  one-hot clause write strobe
- core_clause_o  out  NUM_VARS*2  clause word paired with the strobe
- core_wr_states_o  out  1  var/lvl state write strobe; the top replicates it across the engine's wr_var_states and wr_lvl_states bits
- core_start_o  out  1  start_core pulse
- core_base_lvl_en_o  out  1  base_lvl_en pulse, coincident with core_start_o
- core_rd_carray_o  out  NUM_CLAUSES  one-hot clause read strobe
- core_clause_i  in  NUM_VARS*2  engine clause_o; valid 1 cycle after the read strobe
- core_done_i, core_sat_i, core_unsat_i  in  1 each  engine status
- core_bkt_lvl_i  in  WIDTH_LVL  engine backtrack level

## Operation
- States: IDLE → WR_CL → WR_ST → START → WAIT → RD_REQ → RD_CAP → RD_OUT → (RD_REQ or FIN) → IDLE. TIMEOUT goes WAIT → FIN.
- Clause index counter `idx` is $clog2(NUM_CLAUSES)+1 bits wide and is cleared on entering WR_CL and RD_REQ.
- WR_CL: each handshake (valid & ready) drives `core_wr_carray_o = 1<<idx` and `core_clause_o = in_clause_i` for exactly the next cycle, then increments `idx`. After beat NUM_CLAUSES-1, go to WR_ST.
- WR_ST: `core_wr_states_o = 1` for one cycle. START: `core_start_o = core_base_lvl_en_o = 1` for one cycle.
- WAIT: `core_done_i` is ignored in the START cycle and the cycle after it, so a stale done is never taken. On done, latch the result with priority unsat > sat > else: UNSAT, else PSAT, else BKT. Latch `bkt_lvl_o` at the same time.
- RD_REQ: assert `core_rd_carray_o = 1<<idx` for one cycle.
- RD_CAP: capture `core_clause_i` into `out_clause_o` and set valid.
- RD_OUT: hold the word until `out_clause_ready_i`, then drop valid and increment `idx`. Loop back to RD_REQ until NUM_CLAUSES words have been sent.
- FIN: `done_o = 1` for one cycle, then IDLE.
- Boundary cases:
  - `load_start_i` while busy is ignored.
  - `in_clause_valid_i` outside WR_CL is ignored.
  - `core_done_i` outside WAIT is ignored.
  - If `out_clause_ready_i` stays low, the block stalls in RD_OUT and issues no further read strobes.

## Timing
- Reset values: every output is 0 (including `result_o = 0` and `bkt_lvl_o = 0`); state is IDLE.
- Reset asserted mid-operation: all engine strobes are low from the cycle after reset is sampled.
- `load_start_i` sampled at edge N gives WR_CL and `in_clause_ready_o = 1` in cycle N+1.
- Write strobe latency: one cycle after the handshake. Strobes are never simultaneous with `core_wr_states_o` or `core_start_o`.
- `core_wr_states_o` is asserted in the cycle after the last clause strobe. `core_start_o` follows in the next cycle.
- Readback: 3 cycles per word with `out_clause_ready_i` held high. The read strobe and capture are exactly 1 cycle apart.
- `done_o` is asserted the cycle after the last readback handshake. `result_o` is valid from that cycle onward.

## Configuration
- `CORE_BIN_LOADER_TIMEOUT_EN` defined:
  - A 32-bit counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES with no `core_done_i`, the block sets `result_o = 3`, skips readback, goes to FIN, and pulses `done_o`.
  - If `core_done_i` arrives in the same cycle the counter hits the limit, done wins.
- Macro undefined: WAIT is unbounded, `result_o` is never 3, and TIMEOUT_CYCLES is unused.

## Test plan
- Full load, always-valid input: 8 clauses 0x0001..0x0080 → `core_wr_carray_o` steps 0x01..0x80 on 8 consecutive cycles with matching words, then 1 cycle of `core_wr_states_o`, then 1 cycle of `core_start_o` with `core_base_lvl_en_o`.
- Model engine returns done with sat=1 and unsat=1 → `result_o = 2`. Returns sat only → `result_o = 0`. Returns neither with bkt_lvl = 5 → `result_o = 1` and `bkt_lvl_o = 5`.
- Readback with `out_clause_ready_i` low for 10 cycles on word 3 → `out_clause_o` stays stable, `core_rd_carray_o` stays 0 during the stall, and all 8 words are delivered in order before `done_o`.
- Stale `core_done_i = 1` held high across START → it is not taken as completion until the second cycle after `core_start_o`.
- `rst` pulsed during WR_CL beat 4 → all outputs 0 the next cycle; a fresh load then completes normally.
- With the macro defined and TIMEOUT_CYCLES = 20, no done → `done_o` pulses with `result_o = 3` and no read strobes are issued.
